tlb_mport: RTL and testbench
============================

Name: tlb_mport

Overview:
- Fully-associative LoongArch TLB array and the parametrised successor of the single-configuration two-port TLB.
- Generalised in entry count and number of search ports: NSPORT independent search ports for IF/MEM/probe, plus one write port, one read port and an INVTLB port.
- Adds reset clearing of all entries, a fill-index generator (lowest invalid entry first, otherwise LFSR random) and illegal-INVTLB-op reporting.
- Sits between the CSR/TLB-instruction unit and the IF/EX address-translation stages.

Parameters:
- TLBNUM, 32, number of entries; power of two, 2..64.
- NSPORT, 2, number of search ports, 1..4.
- IDXW, $clog2(TLBNUM), index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_fetch  in  NSPORT  per-port search request.
- s_vppn  in  19*NSPORT  VA[31:13], port k at [19k+18:19k].
- s_odd_page  in  NSPORT  VA[12].
- s_asid  in  10*NSPORT  per-port ASID.
- s_found  out  NSPORT  registered hit.
- s_index  out  IDXW*NSPORT  registered hit index.
- s_ps  out  6*NSPORT  page size of the hit entry.
- s_ppn  out  20*NSPORT  PPN of the selected half.
- s_v, s_d  out  NSPORT each  V and D of the selected half.
- s_mat, s_plv  out  2*NSPORT each  MAT and PLV of the selected half.
- s_multi  out  NSPORT  registered multi-hit flag (Optional Feature).
- we  in  1  write enable.
- w_index  in  IDXW  write index.
- w_vppn[19], w_asid[10], w_g, w_ps[6], w_e, w_v0, w_d0, w_mat0[2], w_plv0[2], w_ppn0[20], w_v1, w_d1, w_mat1[2], w_plv1[2], w_ppn1[20]  in  entry fields.
- r_index  in  IDXW  read index.
- r_vppn, r_asid, r_g, r_ps, r_e, r_v0, r_d0, r_mat0, r_plv0, r_ppn0, r_v1, r_d1, r_mat1, r_plv1, r_ppn1  out  widths as the w_* fields  combinational read of entry r_index.
- inv_en  in  1  INVTLB strobe.
- inv_op  in  5  INVTLB op.
- inv_asid  in  10  INVTLB ASID.
- inv_vpn  in  19  INVTLB VPPN.
- inv_err  out  1  registered pulse for an illegal op.
- fill_adv  in  1  advance the LFSR (one TLBFILL retired).
- fill_index  out  IDXW  index for the next TLBFILL.

Behaviour:
- Reset (async): every entry field cleared to 0, including E. All s_* outputs 0, inv_err 0, LFSR = 16'hACE1.
- Match for entry i, port k, all three required:
  - E=1;
  - ASID equal or G=1;
  - VPPN compare: ps==12 compares all 19 bits; ps==21 compares [18:9]; any other ps never matches.
- Half select: odd = odd_page when ps==12, vppn[8] when ps==21.
- Multiple hits: the lowest index wins.
- Search latency is 1 cycle. When s_fetch[k]=1, s_found[k] is updated next edge.
  - Payload (index, ps, ppn, v, d, mat, plv) is updated only on a hit.
  - On a miss, found=0 and payload holds its previous value.
  - When s_fetch[k]=0, all port-k outputs hold.
- Write: entry w_index is updated on the edge, all fields including E.
  - A search in the same cycle sees the old contents; the new contents are visible from the next cycle.
  - The read port is combinational from the array and reflects a write one cycle after we.
- INVTLB, applied on the edge when inv_en=1, same cycle for all entries:
  - op0, op1: clear all E.
  - op2: clear E where G=1.
  - op3: clear E where G=0.
  - op4: clear E where G=0 and ASID==inv_asid.
  - op5: clear E where G=0, ASID match and VPPN match.
  - op6: clear E where (G=1 or ASID match) and VPPN match.
  - VPPN match for op5/op6 follows the search rule (ps==21 compares [18:9]).
  - op>6: no entry change; inv_err=1 for exactly one cycle.
- Simultaneous we and inv_en: entry w_index takes the write, including w_e. All other entries take the invalidation.
- Fill: fill_index = lowest index with E=0. If all entries are valid, fill_index = lfsr[IDXW-1:0].
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps on each edge with fill_adv=1.
  - fill_index is combinational from registered state.
- A reset mid-search discards the in-flight result.

Optional Feature:
- TLB_MULTIHIT_EN defined: on each fetch, s_multi[k] registers 1 if two or more entries match, else 0. It holds when s_fetch[k]=0 and is cleared by reset. Index selection is unchanged.
- Undefined: s_multi is tied to 0 and no duplicate-detect logic is built.

Test Plan:
- Reset, then search vppn=0x12345 asid=1 on port 0 -> s_found=0; fill_index=0; r_e=0 for every index.
- Write idx3 (vppn=0x12345, ps=12, asid=1, e=1, ppn1=0xABCDE, v1=1); search with odd_page=1 next cycle -> found=1, index=3, ppn=0xABCDE, v=1.
- Write idx5 with ps=21, vppn=0x00200; search vppn=0x003FF, odd_page=0 -> hit, odd half selected via vppn[8]=1; search vppn=0x00400 -> miss, payload held.
- With idx3 (G=0, asid=1) and idx7 (G=1) valid: inv op4 asid=1 -> idx3 E=0, idx7 E=1. Then inv op7 -> inv_err pulse for one cycle, no entry change.
- Same cycle: we to idx2 with e=1 and inv op0 -> idx2 E=1, all others 0. A search issued in that cycle sees the pre-edge contents.
- Fill all 32 entries, then pulse fill_adv 3 times from reset seed -> fill_index follows lfsr[4:0] of the steps. With TLB_MULTIHIT_EN, duplicate entries idx1/idx4 -> s_multi=1, index=1.

Source files
------------

// File: rtl/tlb_mport.sv
// Fully-associative LoongArch TLB: NSPORT registered search ports, write/read/INVTLB ports, fill-index generator.
// Optional feature macro: TLB_MULTIHIT_EN (drives s_multi with duplicate-hit detection).
module tlb_mport #(
  parameter int TLBNUM = 32,
  parameter int NSPORT = 2,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSPORT-1:0]      s_fetch,
  input  logic [19*NSPORT-1:0]   s_vppn,
  input  logic [NSPORT-1:0]      s_odd_page,
  input  logic [10*NSPORT-1:0]   s_asid,
  output logic [NSPORT-1:0]      s_found,
  output logic [IDXW*NSPORT-1:0] s_index,
  output logic [6*NSPORT-1:0]    s_ps,
  output logic [20*NSPORT-1:0]   s_ppn,
  output logic [NSPORT-1:0]      s_v,
  output logic [NSPORT-1:0]      s_d,
  output logic [2*NSPORT-1:0]    s_mat,
  output logic [2*NSPORT-1:0]    s_plv,
  output logic [NSPORT-1:0]      s_multi,
  input  logic                   we,
  input  logic [IDXW-1:0]        w_index,
  input  logic [18:0]            w_vppn,
  input  logic [9:0]             w_asid,
  input  logic                   w_g,
  input  logic [5:0]             w_ps,
  input  logic                   w_e,
  input  logic                   w_v0,
  input  logic                   w_d0,
  input  logic [1:0]             w_mat0,
  input  logic [1:0]             w_plv0,
  input  logic [19:0]            w_ppn0,
  input  logic                   w_v1,
  input  logic                   w_d1,
  input  logic [1:0]             w_mat1,
  input  logic [1:0]             w_plv1,
  input  logic [19:0]            w_ppn1,
  input  logic [IDXW-1:0]        r_index,
  output logic [18:0]            r_vppn,
  output logic [9:0]             r_asid,
  output logic                   r_g,
  output logic [5:0]             r_ps,
  output logic                   r_e,
  output logic                   r_v0,
  output logic                   r_d0,
  output logic [1:0]             r_mat0,
  output logic [1:0]             r_plv0,
  output logic [19:0]            r_ppn0,
  output logic                   r_v1,
  output logic                   r_d1,
  output logic [1:0]             r_mat1,
  output logic [1:0]             r_plv1,
  output logic [19:0]            r_ppn1,
  input  logic                   inv_en,
  input  logic [4:0]             inv_op,
  input  logic [9:0]             inv_asid,
  input  logic [18:0]            inv_vpn,
  output logic                   inv_err,
  input  logic                   fill_adv,
  output logic [IDXW-1:0]        fill_index
);

  typedef struct packed {
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic        e;
    logic        v0;
    logic        d0;
    logic [1:0]  mat0;
    logic [1:0]  plv0;
    logic [19:0] ppn0;
    logic        v1;
    logic        d1;
    logic [1:0]  mat1;
    logic [1:0]  plv1;
    logic [19:0] ppn1;
  } tlbEntry_t;

  tlbEntry_t entry_q [TLBNUM];
  tlbEntry_t wEntry;

  logic [NSPORT-1:0]      sFound_q;
  logic [IDXW*NSPORT-1:0] sIndex_q;
  logic [6*NSPORT-1:0]    sPs_q;
  logic [20*NSPORT-1:0]   sPpn_q;
  logic [NSPORT-1:0]      sV_q;
  logic [NSPORT-1:0]      sD_q;
  logic [2*NSPORT-1:0]    sMat_q;
  logic [2*NSPORT-1:0]    sPlv_q;
  logic                   invErr_q;
  logic [15:0]            lfsr_q;
  logic [15:0]            lfsr_d;

  logic [NSPORT-1:0]      hitAny;
  logic [NSPORT-1:0]      hitOdd;
  logic [IDXW-1:0]        hitIdx [NSPORT];
  logic [TLBNUM-1:0]      invClr;
  logic [IDXW-1:0]        fillIdx;

  assign wEntry = {w_vppn, w_asid, w_g, w_ps, w_e, w_v0, w_d0, w_mat0, w_plv0, w_ppn0,
                   w_v1, w_d1, w_mat1, w_plv1, w_ppn1};

  // Only 4K (ps=12) and 2M (ps=21) pages exist; a 2M page ignores vppn[8:0].
  function automatic logic vpnHit(tlbEntry_t ent, logic [18:0] vppn);
    logic hit;
    hit = 1'b0;
    if (ent.ps == 6'd12)
      hit = (ent.vppn == vppn);
    else if (ent.ps == 6'd21)
      hit = (ent.vppn[18:9] == vppn[18:9]);
    return hit;
  endfunction

`ifdef TLB_MULTIHIT_EN
  logic [NSPORT-1:0] hitMulti;
  logic [NSPORT-1:0] sMulti_q;
`endif

  always_comb begin
    hitAny = '0;
    hitOdd = '0;
`ifdef TLB_MULTIHIT_EN
    hitMulti = '0;
`endif
    for (int k = 0; k < NSPORT; k++) begin
      hitIdx[k] = '0;
      for (int i = 0; i < TLBNUM; i++) begin
        if (entry_q[i].e && (entry_q[i].g || entry_q[i].asid == s_asid[10*k +: 10]) &&
            vpnHit(entry_q[i], s_vppn[19*k +: 19])) begin
`ifdef TLB_MULTIHIT_EN
          if (hitAny[k])
            hitMulti[k] = 1'b1;
`endif
          if (!hitAny[k])
            hitIdx[k] = IDXW'(i);
          hitAny[k] = 1'b1;
        end
      end
      hitOdd[k] = (entry_q[hitIdx[k]].ps == 6'd12) ? s_odd_page[k] : s_vppn[19*k + 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sFound_q <= '0;
      sIndex_q <= '0;
      sPs_q    <= '0;
      sPpn_q   <= '0;
      sV_q     <= '0;
      sD_q     <= '0;
      sMat_q   <= '0;
      sPlv_q   <= '0;
    end else begin
      for (int k = 0; k < NSPORT; k++) begin
        if (s_fetch[k]) begin
          sFound_q[k] <= hitAny[k];
          if (hitAny[k]) begin
            sIndex_q[IDXW*k +: IDXW] <= hitIdx[k];
            sPs_q[6*k +: 6]          <= entry_q[hitIdx[k]].ps;
            sPpn_q[20*k +: 20] <= hitOdd[k] ? entry_q[hitIdx[k]].ppn1 : entry_q[hitIdx[k]].ppn0;
            sV_q[k]            <= hitOdd[k] ? entry_q[hitIdx[k]].v1   : entry_q[hitIdx[k]].v0;
            sD_q[k]            <= hitOdd[k] ? entry_q[hitIdx[k]].d1   : entry_q[hitIdx[k]].d0;
            sMat_q[2*k +: 2]   <= hitOdd[k] ? entry_q[hitIdx[k]].mat1 : entry_q[hitIdx[k]].mat0;
            sPlv_q[2*k +: 2]   <= hitOdd[k] ? entry_q[hitIdx[k]].plv1 : entry_q[hitIdx[k]].plv0;
          end
        end
      end
    end
  end

`ifdef TLB_MULTIHIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sMulti_q <= '0;
    end else begin
      for (int k = 0; k < NSPORT; k++)
        if (s_fetch[k])
          sMulti_q[k] <= hitMulti[k];
    end
  end
  assign s_multi = sMulti_q;
`else
  assign s_multi = '0;
`endif

  always_comb begin
    invClr = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        5'd0, 5'd1: invClr[i] = 1'b1;
        5'd2:       invClr[i] = entry_q[i].g;
        5'd3:       invClr[i] = !entry_q[i].g;
        5'd4:       invClr[i] = !entry_q[i].g && (entry_q[i].asid == inv_asid);
        5'd5:       invClr[i] = !entry_q[i].g && (entry_q[i].asid == inv_asid) &&
                                vpnHit(entry_q[i], inv_vpn);
        5'd6:       invClr[i] = (entry_q[i].g || entry_q[i].asid == inv_asid) &&
                                vpnHit(entry_q[i], inv_vpn);
        default:    invClr[i] = 1'b0;
      endcase
    end
  end

  // A write to an entry overrides a simultaneous invalidation of that same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++)
        entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && w_index == IDXW'(i))
          entry_q[i] <= wEntry;
        else if (inv_en && invClr[i])
          entry_q[i].e <= 1'b0;
      end
    end
  end

  assign lfsr_d = fill_adv ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      invErr_q <= 1'b0;
      lfsr_q   <= 16'hACE1;
    end else begin
      invErr_q <= inv_en && (inv_op > 5'd6);
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    fillIdx = lfsr_q[IDXW-1:0];
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (!entry_q[i].e)
        fillIdx = IDXW'(i);
  end

  assign fill_index = fillIdx;
  assign inv_err    = invErr_q;
  assign s_found    = sFound_q;
  assign s_index    = sIndex_q;
  assign s_ps       = sPs_q;
  assign s_ppn      = sPpn_q;
  assign s_v        = sV_q;
  assign s_d        = sD_q;
  assign s_mat      = sMat_q;
  assign s_plv      = sPlv_q;

  assign r_vppn = entry_q[r_index].vppn;
  assign r_asid = entry_q[r_index].asid;
  assign r_g    = entry_q[r_index].g;
  assign r_ps   = entry_q[r_index].ps;
  assign r_e    = entry_q[r_index].e;
  assign r_v0   = entry_q[r_index].v0;
  assign r_d0   = entry_q[r_index].d0;
  assign r_mat0 = entry_q[r_index].mat0;
  assign r_plv0 = entry_q[r_index].plv0;
  assign r_ppn0 = entry_q[r_index].ppn0;
  assign r_v1   = entry_q[r_index].v1;
  assign r_d1   = entry_q[r_index].d1;
  assign r_mat1 = entry_q[r_index].mat1;
  assign r_plv1 = entry_q[r_index].plv1;
  assign r_ppn1 = entry_q[r_index].ppn1;

endmodule

// File: tb/tb_tlb_mport.sv
// Self-checking bench for tlb_mport: directed vector table, hand sequences and a random run
// against a VA-level reference model of the TLB.
module tb_tlb_mport;
  localparam int TLBNUM = 32;
  localparam int NSPORT = 2;
  localparam int IDXW   = 5;

  typedef struct packed {
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic        e;
    logic        v0;
    logic        d0;
    logic [1:0]  mat0;
    logic [1:0]  plv0;
    logic [19:0] ppn0;
    logic        v1;
    logic        d1;
    logic [1:0]  mat1;
    logic [1:0]  plv1;
    logic [19:0] ppn1;
  } ent_t;

  typedef struct {
    bit          we;
    int          widx;
    ent_t        went;
    bit          fetch;
    logic [18:0] svppn;
    bit          sodd;
    logic [9:0]  sasid;
    bit          expFound;
    int          expIdx;
    logic [19:0] expPpn;
    bit          expV;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NSPORT-1:0]      s_fetch, s_odd_page, s_found, s_v, s_d, s_multi;
  logic [19*NSPORT-1:0]   s_vppn;
  logic [10*NSPORT-1:0]   s_asid;
  logic [IDXW*NSPORT-1:0] s_index;
  logic [6*NSPORT-1:0]    s_ps;
  logic [20*NSPORT-1:0]   s_ppn;
  logic [2*NSPORT-1:0]    s_mat, s_plv;
  logic                   we;
  logic [IDXW-1:0]        w_index, r_index, fill_index;
  ent_t                   wEnt, rEnt;
  logic                   inv_en, inv_err, fill_adv;
  logic [4:0]             inv_op;
  logic [9:0]             inv_asid;
  logic [18:0]            inv_vpn;
  logic [18:0] r_vppn;
  logic [9:0]  r_asid;
  logic        r_g, r_e, r_v0, r_d0, r_v1, r_d1;
  logic [5:0]  r_ps;
  logic [1:0]  r_mat0, r_plv0, r_mat1, r_plv1;
  logic [19:0] r_ppn0, r_ppn1;

  assign rEnt = {r_vppn, r_asid, r_g, r_ps, r_e, r_v0, r_d0, r_mat0, r_plv0, r_ppn0,
                 r_v1, r_d1, r_mat1, r_plv1, r_ppn1};

  tlb_mport #(.TLBNUM(TLBNUM), .NSPORT(NSPORT)) dut (
    .clk(clk), .reset(reset),
    .s_fetch(s_fetch), .s_vppn(s_vppn), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ps(s_ps), .s_ppn(s_ppn), .s_v(s_v), .s_d(s_d),
    .s_mat(s_mat), .s_plv(s_plv), .s_multi(s_multi),
    .we(we), .w_index(w_index), .w_vppn(wEnt.vppn), .w_asid(wEnt.asid), .w_g(wEnt.g),
    .w_ps(wEnt.ps), .w_e(wEnt.e), .w_v0(wEnt.v0), .w_d0(wEnt.d0), .w_mat0(wEnt.mat0),
    .w_plv0(wEnt.plv0), .w_ppn0(wEnt.ppn0), .w_v1(wEnt.v1), .w_d1(wEnt.d1),
    .w_mat1(wEnt.mat1), .w_plv1(wEnt.plv1), .w_ppn1(wEnt.ppn1),
    .r_index(r_index), .r_vppn(r_vppn), .r_asid(r_asid), .r_g(r_g), .r_ps(r_ps), .r_e(r_e),
    .r_v0(r_v0), .r_d0(r_d0), .r_mat0(r_mat0), .r_plv0(r_plv0), .r_ppn0(r_ppn0),
    .r_v1(r_v1), .r_d1(r_d1), .r_mat1(r_mat1), .r_plv1(r_plv1), .r_ppn1(r_ppn1),
    .inv_en(inv_en), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
    .inv_err(inv_err), .fill_adv(fill_adv), .fill_index(fill_index)
  );

  // Reference model state: the TLB contents plus what each search port last reported.
  ent_t        mEnt [TLBNUM];
  bit          mFound [NSPORT];
  logic [IDXW-1:0] mIdx [NSPORT];
  logic [5:0]  mPs [NSPORT];
  logic [19:0] mPpn [NSPORT];
  bit          mV [NSPORT], mD [NSPORT], mMulti [NSPORT];
  logic [1:0]  mMat [NSPORT], mPlv [NSPORT];
  bit          mInvErr;
  logic [15:0] mLfsr;
  int          nErrors = 0;
  int          nChecks = 0;

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < TLBNUM; i++) mEnt[i] = '0;
    for (int k = 0; k < NSPORT; k++) begin
      mFound[k] = 0; mIdx[k] = '0; mPs[k] = '0; mPpn[k] = '0;
      mV[k] = 0; mD[k] = 0; mMat[k] = '0; mPlv[k] = '0; mMulti[k] = 0;
    end
    mInvErr = 0;
    mLfsr = 16'hACE1;
  endtask

  // Page-frame compare at VA level: the page covers 2^(ps+1) bytes (even+odd halves).
  function automatic bit pageMatch(ent_t e, logic [18:0] vppn);
    logic [31:0] va, ea;
    int sh;
    if (e.ps != 6'd12 && e.ps != 6'd21) return 0;
    sh = int'(e.ps) + 1;
    va = {vppn, 13'b0};
    ea = {e.vppn, 13'b0};
    return (va >> sh) == (ea >> sh);
  endfunction

  function automatic bit invClears(ent_t e);
    bit asidEq = (e.asid == inv_asid);
    case (inv_op)
      5'd0, 5'd1: return 1;
      5'd2: return e.g;
      5'd3: return !e.g;
      5'd4: return !e.g && asidEq;
      5'd5: return !e.g && asidEq && pageMatch(e, inv_vpn);
      5'd6: return (e.g || asidEq) && pageMatch(e, inv_vpn);
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput();
    int firstFree = -1;
    for (int k = 0; k < NSPORT; k++) begin
      check("found", s_found[k], mFound[k]);
      check("payload", {s_index[IDXW*k +: IDXW], s_ps[6*k +: 6], s_ppn[20*k +: 20], s_v[k], s_d[k],
                        s_mat[2*k +: 2], s_plv[2*k +: 2]},
                       {mIdx[k], mPs[k], mPpn[k], mV[k], mD[k], mMat[k], mPlv[k]});
      check("multi", s_multi[k], mMulti[k]);
    end
    check("inv_err", inv_err, mInvErr);
    for (int i = 0; i < TLBNUM; i++)
      if (firstFree < 0 && !mEnt[i].e) firstFree = i;
    check("fill_index", fill_index, (firstFree >= 0) ? firstFree : (mLfsr % TLBNUM));
    check("read", rEnt, mEnt[r_index]);
  endtask

  // Predict the edge from current inputs (searches see pre-edge contents), then clock and compare.
  task automatic applyStimulus();
    for (int k = 0; k < NSPORT; k++) begin
      if (s_fetch[k]) begin
        int hits[$];
        logic [18:0] vp = s_vppn[19*k +: 19];
        for (int i = 0; i < TLBNUM; i++)
          if (mEnt[i].e && (mEnt[i].g || mEnt[i].asid == s_asid[10*k +: 10]) && pageMatch(mEnt[i], vp))
            hits.push_back(i);
        mFound[k] = hits.size() > 0;
`ifdef TLB_MULTIHIT_EN
        mMulti[k] = hits.size() > 1;
`endif
        if (mFound[k]) begin
          ent_t e = mEnt[hits[0]];
          logic [31:0] va = {vp, s_odd_page[k], 12'b0};
          bit odd = va[e.ps];
          mIdx[k] = IDXW'(hits[0]);
          mPs[k]  = e.ps;
          mPpn[k] = odd ? e.ppn1 : e.ppn0;
          mV[k]   = odd ? e.v1 : e.v0;
          mD[k]   = odd ? e.d1 : e.d0;
          mMat[k] = odd ? e.mat1 : e.mat0;
          mPlv[k] = odd ? e.plv1 : e.plv0;
        end
      end
    end
    mInvErr = inv_en && (inv_op > 6);
    for (int i = 0; i < TLBNUM; i++) begin
      if (we && int'(w_index) == i) mEnt[i] = wEnt;
      else if (inv_en && invClears(mEnt[i])) mEnt[i].e = 0;
    end
    if (fill_adv) mLfsr = (mLfsr >> 1) | (16'(^(mLfsr & 16'h002D)) << 15);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    we = 0; inv_en = 0; fill_adv = 0; s_fetch = '0;
  endtask

  task automatic setSearch(int k, logic [18:0] v, bit odd, logic [9:0] a);
    s_fetch[k] = 1; s_vppn[19*k +: 19] = v; s_odd_page[k] = odd; s_asid[10*k +: 10] = a;
  endtask

  function automatic ent_t mkEnt(logic [18:0] vppn, logic [9:0] asid, bit g, logic [5:0] ps, bit e,
                                 bit v0, logic [19:0] ppn0, bit v1, logic [19:0] ppn1);
    return {vppn, asid, g, ps, e, v0, v0, 2'b01, 2'b11, ppn0, v1, v1, 2'b10, 2'b00, ppn1};
  endfunction

  task automatic checkAllE(string name, int onlyValid);
    for (int i = 0; i < TLBNUM; i++) begin
      r_index = IDXW'(i);
      #1;
      check(name, r_e, (i == onlyValid));
    end
  endtask

  logic [18:0] pool [4];
  vec_t vecs [8];

  initial begin
    pool = '{19'h12345, 19'h00200, 19'h7FE00, 19'h0AAAA};
    reset = 1; we = 0; w_index = '0; wEnt = '0; r_index = '0; inv_en = 0; inv_op = '0;
    inv_asid = '0; inv_vpn = '0; fill_adv = 0; s_fetch = '0; s_vppn = '0; s_odd_page = '0; s_asid = '0;

    vecs[0] = '{0, 0, '0, 1, 19'h12345, 0, 10'd1, 0, 0, 20'h0, 0};
    vecs[1] = '{1, 3, mkEnt(19'h12345, 10'd1, 0, 6'd12, 1, 0, 20'h0, 1, 20'hABCDE),
                0, 19'h0, 0, 10'd0, 0, 0, 20'h0, 0};
    vecs[2] = '{0, 0, '0, 1, 19'h12345, 1, 10'd1, 1, 3, 20'hABCDE, 1};
    vecs[3] = '{1, 5, mkEnt(19'h00200, 10'd1, 0, 6'd21, 1, 0, 20'h11111, 1, 20'h22222),
                1, 19'h12345, 0, 10'd1, 1, 3, 20'h0, 0};
    vecs[4] = '{0, 0, '0, 1, 19'h003FF, 0, 10'd1, 1, 5, 20'h22222, 1};
    vecs[5] = '{0, 0, '0, 1, 19'h00400, 0, 10'd1, 0, 5, 20'h22222, 1};
    vecs[6] = '{1, 7, mkEnt(19'h0AAAA, 10'h3FF, 1, 6'd12, 1, 1, 20'h33333, 0, 20'h0),
                1, 19'h0AAAA, 0, 10'd9, 0, 5, 20'h22222, 1};
    vecs[7] = '{0, 0, '0, 1, 19'h0AAAA, 0, 10'd9, 1, 7, 20'h33333, 1};

    modelReset();
    #3 reset = 0;
    #1;
    checkOutput();
    checkAllE("reset E clear", -1);
    check("reset fill_index", fill_index, 0);

    for (int n = 0; n < 8; n++) begin
      we = vecs[n].we; w_index = IDXW'(vecs[n].widx); wEnt = vecs[n].went;
      if (vecs[n].fetch) setSearch(0, vecs[n].svppn, vecs[n].sodd, vecs[n].sasid);
      applyStimulus();
      check("vec found", s_found[0], vecs[n].expFound);
      check("vec index", s_index[IDXW-1:0], vecs[n].expIdx);
      check("vec ppn", s_ppn[19:0], vecs[n].expPpn);
      check("vec v", s_v[0], vecs[n].expV);
      idle();
    end

    inv_en = 1; inv_op = 5'd4; inv_asid = 10'd1;
    applyStimulus();
    idle();
    r_index = 3; #1; check("inv4 idx3 E", r_e, 0);
    r_index = 7; #1; check("inv4 idx7 E", r_e, 1);
    inv_en = 1; inv_op = 5'd7;
    applyStimulus();
    check("inv_err pulse", inv_err, 1);
    idle();
    applyStimulus();
    check("inv_err drop", inv_err, 0);
    r_index = 7; #1; check("inv7 idx7 E", r_e, 1);

    we = 1; w_index = 2; wEnt = mkEnt(19'h01111, 10'd1, 0, 6'd12, 1, 1, 20'h44444, 0, 20'h0);
    inv_en = 1; inv_op = 5'd0;
    setSearch(0, 19'h0AAAA, 0, 10'd9);
    applyStimulus();
    check("we+inv search old found", s_found[0], 1);
    check("we+inv search old index", s_index[IDXW-1:0], 7);
    idle();
    checkAllE("we+inv E", 2);
    setSearch(0, 19'h0AAAA, 0, 10'd9);
    applyStimulus();
    check("post inv miss", s_found[0], 0);
    idle();

    setSearch(0, 19'h01111, 0, 10'd1);
    #2 reset = 1;
    modelReset();
    @(posedge clk);
    #1;
    check("reset mid-search found", s_found[0], 0);
    checkOutput();
    #3 reset = 0;
    idle();
    #1;
    checkAllE("reset2 E clear", -1);

    for (int i = 0; i < TLBNUM; i++) begin
      we = 1; w_index = IDXW'(i);
      wEnt = mkEnt(19'h40000 + 19'(i), 10'd5, 0, 6'd12, 1, 1, 20'(i), 0, 20'h0);
      applyStimulus();
      check("fill walk", fill_index, (i < TLBNUM - 1) ? i + 1 : 1);
    end
    idle();
    begin
      int lfsrExp [3] = '{16, 24, 28};
      for (int n = 0; n < 3; n++) begin
        fill_adv = 1;
        applyStimulus();
        check("fill lfsr", fill_index, lfsrExp[n]);
      end
    end
    idle();

    we = 1; w_index = 1; wEnt = mkEnt(19'h7000F, 10'd5, 0, 6'd12, 1, 1, 20'h55555, 0, 20'h0);
    applyStimulus();
    w_index = 4; wEnt = mkEnt(19'h7000F, 10'd5, 0, 6'd12, 1, 1, 20'h66666, 0, 20'h0);
    applyStimulus();
    idle();
    setSearch(0, 19'h7000F, 0, 10'd5);
    applyStimulus();
    check("dup found", s_found[0], 1);
    check("dup index", s_index[IDXW-1:0], 1);
`ifdef TLB_MULTIHIT_EN
    check("dup multi", s_multi[0], 1);
`else
    check("dup multi", s_multi[0], 0);
`endif
    idle();

    for (int n = 0; n < 400; n++) begin
      ent_t e;
      e = mkEnt(pool[$urandom_range(0, 3)] ^ ($urandom_range(0, 1) ? 19'($urandom_range(0, 511)) : 19'h0),
                10'($urandom_range(1, 2)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0) ? 6'd13 : (($urandom_range(0, 1) == 0) ? 6'd12 : 6'd21),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 20'($urandom),
                $urandom_range(0, 1), 20'($urandom));
      e.mat0 = 2'($urandom); e.plv1 = 2'($urandom);
      we = ($urandom_range(0, 2) == 0); w_index = IDXW'($urandom); wEnt = e;
      for (int k = 0; k < NSPORT; k++) begin
        if ($urandom_range(0, 1) == 1)
          setSearch(k, pool[$urandom_range(0, 3)] ^ ($urandom_range(0, 1) ? 19'($urandom_range(0, 511)) : 19'h0),
                    $urandom_range(0, 1), 10'($urandom_range(1, 2)));
        else
          s_fetch[k] = 0;
      end
      inv_en = ($urandom_range(0, 15) == 0); inv_op = 5'($urandom_range(0, 8));
      inv_asid = 10'($urandom_range(1, 2)); inv_vpn = pool[$urandom_range(0, 3)];
      fill_adv = $urandom_range(0, 1); r_index = IDXW'($urandom);
      applyStimulus();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
